// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: entry layout, FSM states and the NOP encoding.
package if_pkg;
  localparam int unsigned IF_N   = 32;
  localparam logic [31:0] IF_NOP = 32'hF000_0000;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} if_state_t;

  typedef struct packed {
    logic [IF_N-1:0] pc;
    logic [31:0]     instr;
  } if_entry_t;
endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO of fetched instructions; slot0 is always the head, clear beats push.
module if_fetch_queue
  import if_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  if_entry_t din,
  output if_entry_t head,
  output logic [1:0] count,
  output logic      full,
  output logic      empty
);
  if_entry_t  slot0, slot1;
  logic [1:0] cnt;
  logic       pop_ok, push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; new entry lands behind the survivor.
          if (cnt == 2'd1) slot0 <= din;
          else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign count = cnt;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, one-outstanding imem request FSM, 2-entry buffer, redirects.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module stage_if
  import if_pkg::*;
#(
  parameter int unsigned  N        = IF_N,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  instruction_o,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         valid_o,
  output logic [31:0]  perf_fetch_o,
  output logic [31:0]  perf_stall_o
);
  if_state_t  state, state_d;
  logic [N-1:0] pc, pc_d, req_pc, addr_q, target;
  logic       req_q, issue, push, pop;
  if_entry_t  head, din;
  logic [1:0] count;
  logic       full, empty, unused_full;

  assign target      = {branch_target_i[N-1:2], 2'b00};
  assign valid_o     = !empty;
  assign pop         = valid_o && !stall_i && !branch_taken_i;
  assign din         = '{pc: req_pc, instr: imem_rdata_i};
  assign unused_full = full;

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    push    = 1'b0;
    case (state)
      FETCH: if (!branch_taken_i && count != 2'd2) begin
        issue   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A redirect racing the response drops it; without a response we must drain it later.
        if (imem_rvalid_i) begin
          push    = !branch_taken_i;
          state_d = FETCH;
        end else if (branch_taken_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (imem_rvalid_i) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    pc_d = branch_taken_i ? target : (issue ? pc + N'(4) : pc);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      req_q <= issue;
      if (issue) begin
        req_pc <= pc;
        addr_q <= pc;
      end
    end
  end

  if_fetch_queue u_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .clear (branch_taken_i),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instruction_o = valid_o ? head.instr : IF_NOP;
  assign pc_o          = valid_o ? head.pc : '0;
  assign pc_plus4_o    = pc_o + N'(4);

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && perf_fetch != 32'hFFFF_FFFF)                 perf_fetch <= perf_fetch + 32'd1;
      if (valid_o && stall_i && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch;
  assign perf_stall_o = perf_stall;
`else
  assign perf_fetch_o = '0;
  assign perf_stall_o = '0;
`endif
endmodule
